// File: rtl/fft_input_framer.sv
// fft_input_framer: collects a serial sample stream into 8-sample frames held
// in two ping-pong banks. Each full frame is presented to fft_top with a
// one-cycle start pulse and held until fft_top reports completion.
// Optional build macro FRAMER_DROP_EN: never backpressure; instead drop
// samples that arrive while the write bank is full and count them.
module fft_input_framer #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic              flush_i,
  input  logic              fft_busy_i,
  input  logic              fft_valid_i,
  output logic [DATA_W-1:0] x_0_o,
  output logic [DATA_W-1:0] x_1_o,
  output logic [DATA_W-1:0] x_2_o,
  output logic [DATA_W-1:0] x_3_o,
  output logic [DATA_W-1:0] x_4_o,
  output logic [DATA_W-1:0] x_5_o,
  output logic [DATA_W-1:0] x_6_o,
  output logic [DATA_W-1:0] x_7_o,
  output logic              start_o,
  output logic [15:0]       frame_cnt_o
`ifdef FRAMER_DROP_EN
  ,
  output logic [15:0]       drop_cnt_o
`endif
);

  typedef enum logic [1:0] {D_IDLE, D_WAIT, D_RUN} state_t;

  state_t state, state_nxt;

  logic [1:0][7:0][DATA_W-1:0] bank;
  logic [1:0] full;
  logic       wr_bank;
  logic       rd_bank;
  logic [2:0] wr_idx;

  logic accept;
  logic fill_done;
  logic release_frame;
  logic start_nxt;

  // A same-cycle flush wins over the sample; a full write bank never accepts.
  assign accept    = s_valid_i && !full[wr_bank] && !flush_i;
  assign fill_done = accept && (wr_idx == 3'd7);

`ifdef FRAMER_DROP_EN
  assign s_ready_o = 1'b1;
`else
  assign s_ready_o = !full[wr_bank];
`endif

  // Output mux always shows the read bank; it is full (hence unwritten)
  // for the whole start..release window.
  assign x_0_o = bank[rd_bank][0];
  assign x_1_o = bank[rd_bank][1];
  assign x_2_o = bank[rd_bank][2];
  assign x_3_o = bank[rd_bank][3];
  assign x_4_o = bank[rd_bank][4];
  assign x_5_o = bank[rd_bank][5];
  assign x_6_o = bank[rd_bank][6];
  assign x_7_o = bank[rd_bank][7];

  // Fill path: write pointer, bank select and sample storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bank    <= '0;
      wr_bank <= 1'b0;
      wr_idx  <= '0;
    end else if (flush_i) begin
      wr_idx <= '0;
    end else if (accept) begin
      bank[wr_bank][wr_idx] <= s_data_i;
      if (wr_idx == 3'd7) begin
        wr_idx  <= '0;
        wr_bank <= !wr_bank;
      end else begin
        wr_idx <= wr_idx + 3'd1;
      end
    end
  end

  // Per-bank full flags; set (fill) and clear (release) never target the
  // same bank because fill needs it empty and release needs it full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full <= '0;
    end else begin
      if (fill_done)     full[wr_bank] <= 1'b1;
      if (release_frame) full[rd_bank] <= 1'b0;
    end
  end

  // Dispatch FSM next-state and start/release decode.
  always_comb begin
    state_nxt     = state;
    start_nxt     = 1'b0;
    release_frame = 1'b0;
    case (state)
      D_IDLE: begin
        if (full[rd_bank] && !fft_busy_i) begin
          start_nxt = 1'b1;
          state_nxt = D_WAIT;
        end
      end
      D_WAIT: begin
        if (fft_valid_i) begin
          release_frame = 1'b1;
          state_nxt     = D_IDLE;
        end else if (fft_busy_i) begin
          state_nxt = D_RUN;
        end
      end
      D_RUN: begin
        if (fft_valid_i) begin
          release_frame = 1'b1;
          state_nxt     = D_IDLE;
        end
      end
      default: state_nxt = D_IDLE;
    endcase
  end

  // Dispatch FSM state, registered start pulse, read bank and frame count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= D_IDLE;
      start_o     <= 1'b0;
      rd_bank     <= 1'b0;
      frame_cnt_o <= '0;
    end else begin
      state   <= state_nxt;
      start_o <= start_nxt;
      if (release_frame) begin
        rd_bank     <= !rd_bank;
        frame_cnt_o <= frame_cnt_o + 16'd1;
      end
    end
  end

`ifdef FRAMER_DROP_EN
  logic drop;
  assign drop = s_valid_i && full[wr_bank] && !flush_i;

  // Saturating count of samples discarded against a full write bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_o <= '0;
    end else if (drop && (drop_cnt_o != 16'hFFFF)) begin
      drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end
`endif

endmodule
